debug_stepper: RTL and testbench



---
 rtl/debug_stepper_pkg.sv | 31 +++
 rtl/debug_stepper.sv | 165 ++++++++++++++++
 tb/tb_debug_stepper.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_stepper_pkg.sv
// Shared encodings for the host-side debug stepper: command ops, halt causes, FSM states.
package debug_stepper_pkg;

  // Command op codes carried on cmd_op
  localparam logic [1:0] DBG_OP_HALT  = 2'd0;
  localparam logic [1:0] DBG_OP_RUN   = 2'd1;
  localparam logic [1:0] DBG_OP_STEP  = 2'd2;
  localparam logic [1:0] DBG_OP_RUN_N = 2'd3;

  // Reasons reported on halt_cause
  localparam logic [1:0] DBG_CAUSE_RESET = 2'd0;
  localparam logic [1:0] DBG_CAUSE_CMD   = 2'd1;
  localparam logic [1:0] DBG_CAUSE_COUNT = 2'd2;
  localparam logic [1:0] DBG_CAUSE_BP    = 2'd3;

  // Sequencer states
  typedef enum logic [1:0] {
    DBG_ST_FREE    = 2'd0,
    DBG_ST_HALT    = 2'd1,
    DBG_ST_STEP_HI = 2'd2,
    DBG_ST_STEP_LO = 2'd3
  } dbg_state_e;

  // Width of the shared phase counter: enough for the longer of the two phases
  function automatic int unsigned dbg_phase_w(input int unsigned hi, input int unsigned lo);
    int unsigned mx;
    mx = (hi > lo) ? hi : lo;
    return (mx > 1) ? int'($clog2(mx)) : 1;
  endfunction

endpackage

// File: rtl/debug_stepper.sv
// Debug sequencer driving the controller's debug_en/debug_step: run, halt, step, run-N, PC breakpoint.
module debug_stepper
  import debug_stepper_pkg::*;
#(
  parameter int unsigned STEP_HI_CYCLES = 2,
  parameter int unsigned STEP_LO_CYCLES = 2,
  parameter int unsigned COUNT_W        = 16,
  parameter bit          RESET_HALTED   = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [COUNT_W-1:0] cmd_count,
  input  logic               abort,
  input  logic               bp_en,
  input  logic [31:0]        bp_addr,
  input  logic [31:0]        pc,
  output logic               debug_en,
  output logic               debug_step,
  output logic               halted,
  output logic [1:0]         halt_cause,
  output logic [COUNT_W-1:0] steps_done
);

  localparam int unsigned    PH_W        = dbg_phase_w(STEP_HI_CYCLES, STEP_LO_CYCLES);
  localparam logic [PH_W-1:0] HI_LAST    = PH_W'(STEP_HI_CYCLES - 1);
  localparam logic [PH_W-1:0] LO_LAST    = PH_W'(STEP_LO_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);
  localparam dbg_state_e     RESET_STATE = RESET_HALTED ? DBG_ST_HALT : DBG_ST_FREE;

  dbg_state_e         state_q, state_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [COUNT_W-1:0] remaining_q, remaining_d;
  logic [COUNT_W-1:0] steps_done_q, steps_done_d;
  logic [1:0]         halt_cause_q, halt_cause_d;
  logic               bp_mask_q, bp_mask_d;
  logic               debug_en_q, debug_en_d;
  logic               debug_step_q, debug_step_d;
  logic               halted_q, halted_d;
  logic               cmd_ready_q, cmd_ready_d;

  logic               cmd_accept_c;
  logic               bp_hit_c;
  logic [COUNT_W-1:0] run_count_c;

  assign cmd_accept_c = cmd_valid & cmd_ready_q;
  assign bp_hit_c     = bp_en & (pc == bp_addr);

  // Next-state, counter and registered-output logic
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    remaining_d  = remaining_q;
    steps_done_d = steps_done_q;
    halt_cause_d = halt_cause_q;
    bp_mask_d    = 1'b0;
    run_count_c  = (cmd_op == DBG_OP_STEP) ? CNT_ONE : cmd_count;

    unique case (state_q)
      DBG_ST_FREE, DBG_ST_HALT: begin
        if (cmd_accept_c) begin
          steps_done_d = '0;
          unique case (cmd_op)
            DBG_OP_HALT: begin
              state_d      = DBG_ST_HALT;
              halt_cause_d = DBG_CAUSE_CMD;
            end
            DBG_OP_RUN: begin
              state_d   = DBG_ST_FREE;
              // Let the CPU leave a PC that still matches the breakpoint
              bp_mask_d = 1'b1;
            end
            default: begin
              remaining_d = run_count_c;
              phase_d     = '0;
              if (run_count_c == '0) begin
                state_d      = DBG_ST_HALT;
                halt_cause_d = DBG_CAUSE_COUNT;
              end else begin
                state_d = DBG_ST_STEP_HI;
              end
            end
          endcase
        end else if ((state_q == DBG_ST_FREE) && bp_hit_c && !bp_mask_q) begin
          state_d      = DBG_ST_HALT;
          halt_cause_d = DBG_CAUSE_BP;
        end
      end

      DBG_ST_STEP_HI: begin
        if (phase_q == HI_LAST) begin
          state_d = DBG_ST_STEP_LO;
          phase_d = '0;
          if (steps_done_q != CNT_MAX) steps_done_d = steps_done_q + CNT_ONE;
          if (remaining_q != '0)       remaining_d  = remaining_q - CNT_ONE;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      DBG_ST_STEP_LO: begin
        if (phase_q == LO_LAST) begin
          phase_d = '0;
          if (abort) begin
            state_d      = DBG_ST_HALT;
            halt_cause_d = DBG_CAUSE_CMD;
          end else if (bp_hit_c) begin
            state_d      = DBG_ST_HALT;
            halt_cause_d = DBG_CAUSE_BP;
          end else if (remaining_q == '0) begin
            state_d      = DBG_ST_HALT;
            halt_cause_d = DBG_CAUSE_COUNT;
          end else begin
            state_d = DBG_ST_STEP_HI;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
    endcase

    debug_en_d   = (state_d != DBG_ST_FREE);
    debug_step_d = (state_d == DBG_ST_STEP_HI);
    halted_d     = (state_d == DBG_ST_HALT);
    cmd_ready_d  = (state_d == DBG_ST_FREE) || (state_d == DBG_ST_HALT);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RESET_STATE;
      phase_q      <= '0;
      remaining_q  <= '0;
      steps_done_q <= '0;
      halt_cause_q <= DBG_CAUSE_RESET;
      bp_mask_q    <= 1'b0;
      debug_en_q   <= RESET_HALTED;
      debug_step_q <= 1'b0;
      halted_q     <= RESET_HALTED;
      cmd_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      remaining_q  <= remaining_d;
      steps_done_q <= steps_done_d;
      halt_cause_q <= halt_cause_d;
      bp_mask_q    <= bp_mask_d;
      debug_en_q   <= debug_en_d;
      debug_step_q <= debug_step_d;
      halted_q     <= halted_d;
      cmd_ready_q  <= cmd_ready_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign debug_en   = debug_en_q;
  assign debug_step = debug_step_q;
  assign halted     = halted_q;
  assign halt_cause = halt_cause_q;
  assign steps_done = steps_done_q;

endmodule

// File: tb/tb_debug_stepper.sv
// Bench for debug_stepper: directed + randomized command sequences against a step-level model.
module tb_debug_stepper;
  import debug_stepper_pkg::*;

  localparam int unsigned HI = 2;
  localparam int unsigned LO = 3;
  localparam int unsigned CW = 8;
  localparam int unsigned P  = HI + LO;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [CW-1:0] cmd_count;
  logic          abort;
  logic          bp_en;
  logic [31:0]   bp_addr;
  logic [31:0]   pc;
  logic          debug_en;
  logic          debug_step;
  logic          halted;
  logic [1:0]    halt_cause;
  logic [CW-1:0] steps_done;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  debug_stepper #(
    .STEP_HI_CYCLES(HI),
    .STEP_LO_CYCLES(LO),
    .COUNT_W       (CW),
    .RESET_HALTED  (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_count (cmd_count),
    .abort     (abort),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .pc        (pc),
    .debug_en  (debug_en),
    .debug_step(debug_step),
    .halted    (halted),
    .halt_cause(halt_cause),
    .steps_done(steps_done)
  );

  // Controller/CPU stand-in: rising-edge step detector and a PC counting by 4 per enabled cycle
  logic        step_prev = 1'b0;
  logic        cpu_en;
  logic        pc_ld = 1'b1;
  logic [31:0] pc_ld_val = 32'h0;
  int          edge_cnt = 0;
  int          cpu_cycles = 0;

  assign cpu_en = !debug_en || (debug_step && !step_prev);

  always @(posedge clk) begin
    step_prev <= debug_step;
    if (debug_step && !step_prev) edge_cnt <= edge_cnt + 1;
    if (cpu_en === 1'b1) cpu_cycles <= cpu_cycles + 1;
    if (pc_ld)                pc <= pc_ld_val;
    else if (cpu_en === 1'b1) pc <= pc + 32'd4;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Step-level model: which step ends the sequence and why
  function automatic void model(input int n, input int a, input logic be, input logic [31:0] ba,
                                input logic [31:0] pc0, output int h, output logic [1:0] cause);
    h     = 0;
    cause = DBG_CAUSE_COUNT;
    for (int s = 1; s <= n; s++) begin
      h = s;
      if (s == a) begin
        cause = DBG_CAUSE_CMD;
        return;
      end
      if (be && (ba == pc0 + 32'(4 * s))) begin
        cause = DBG_CAUSE_BP;
        return;
      end
    end
  endfunction

  // Present one command at a negedge; returns at the negedge of the first cycle after acceptance
  task automatic send_cmd(input logic [1:0] op, input logic [CW-1:0] cnt);
    int w = 0;
    while (cmd_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Issue STEP/RUN_N from HALT and check pulse train, handshake and final status
  task automatic run_check(input string tag, input logic [1:0] op, input int n_arg, input int a);
    int          n;
    int          h;
    int          e0;
    int          c0;
    logic [1:0]  cause;
    logic [31:0] pc0;
    n   = (op == DBG_OP_STEP) ? 1 : n_arg;
    pc0 = pc;
    model(n, a, bp_en, bp_addr, pc0, h, cause);
    e0 = edge_cnt;
    c0 = cpu_cycles;
    send_cmd(op, CW'(n_arg));
    for (int t = 1; t <= h * int'(P); t++) begin
      check({tag, "_step"},  32'(debug_step), 32'(((t - 1) % int'(P)) < int'(HI)));
      check({tag, "_ready"}, 32'(cmd_ready),  32'd0);
      check({tag, "_en"},    32'(debug_en),   32'd1);
      if (a != 0 && t == (a - 1) * int'(P) + int'(HI)) abort = 1'b1;
      @(negedge clk);
    end
    check({tag, "_halted"}, 32'(halted),         32'd1);
    check({tag, "_cause"},  32'(halt_cause),     32'(cause));
    check({tag, "_done"},   32'(steps_done),     32'(h));
    check({tag, "_edges"},  32'(edge_cnt - e0),  32'(h));
    check({tag, "_cpu"},    32'(cpu_cycles - c0), 32'(h));
    check({tag, "_ready_end"}, 32'(cmd_ready),   32'd1);
    abort = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          found;
    int          e0;
    int          n;
    int          a;
    logic [1:0]  op;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_count = '0;
    abort     = 1'b0;
    bp_en     = 1'b0;
    bp_addr   = 32'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pc_ld = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_en",     32'(debug_en),   32'd1);
    check("rst_step",   32'(debug_step), 32'd0);
    check("rst_halted", 32'(halted),     32'd1);
    check("rst_cause",  32'(halt_cause), 32'(DBG_CAUSE_RESET));
    check("rst_ready",  32'(cmd_ready),  32'd1);
    check("rst_done",   32'(steps_done), 32'd0);

    // HALT while halted
    send_cmd(DBG_OP_HALT, '0);
    check("halt_halted", 32'(halted),     32'd1);
    check("halt_cause",  32'(halt_cause), 32'(DBG_CAUSE_CMD));
    check("halt_en",     32'(debug_en),   32'd1);

    // Directed stepping scenarios
    run_check("step",   DBG_OP_STEP,  0,   0);
    run_check("runn5",  DBG_OP_RUN_N, 5,   0);
    run_check("runn0",  DBG_OP_RUN_N, 0,   0);
    run_check("abort3", DBG_OP_RUN_N, 100, 3);

    // Randomized run-N with optional abort and breakpoint
    for (int i = 0; i < 12; i++) begin
      n  = int'($urandom_range(0, 6));
      op = (n == 1 && $urandom_range(0, 1) == 1) ? DBG_OP_STEP : DBG_OP_RUN_N;
      a  = ($urandom_range(0, 1) == 1 && n > 0) ? int'($urandom_range(1, n)) : 0;
      bp_en   = 1'($urandom_range(0, 1));
      bp_addr = pc + 32'(4 * $urandom_range(1, n + 1));
      run_check("rand", op, n, a);
    end
    bp_en = 1'b0;

    // Free-run breakpoint at 0x20 with PC counting from 0
    pc_ld     = 1'b1;
    pc_ld_val = 32'h0;
    @(negedge clk);
    pc_ld   = 1'b0;
    bp_en   = 1'b1;
    bp_addr = 32'h20;
    send_cmd(DBG_OP_RUN, '0);
    check("free_en", 32'(debug_en), 32'd0);
    found = 0;
    for (int t = 0; t < 40 && found == 0; t++) begin
      if (pc == 32'h20) begin
        check("bp_en_at_match", 32'(debug_en), 32'd0);
        @(negedge clk);
        check("bp_en_after", 32'(debug_en), 32'd1);
        found = 1;
      end else begin
        @(negedge clk);
      end
    end
    check("bp_found",  32'(found),      32'd1);
    check("bp_cause",  32'(halt_cause), 32'(DBG_CAUSE_BP));
    check("bp_halted", 32'(halted),     32'd1);
    check("bp_pc",     pc,              32'h24);

    // RUN while sitting on the breakpoint must proceed past it
    pc_ld     = 1'b1;
    pc_ld_val = 32'h20;
    @(negedge clk);
    pc_ld = 1'b0;
    send_cmd(DBG_OP_RUN, '0);
    check("mask_pc",  pc,            32'h20);
    check("mask_en0", 32'(debug_en), 32'd0);
    repeat (3) @(negedge clk);
    check("mask_en3",     32'(debug_en), 32'd0);
    check("mask_pc_past", pc,            32'h2c);
    bp_en = 1'b0;
    send_cmd(DBG_OP_HALT, '0);
    check("free_halt",       32'(halted),     32'd1);
    check("free_halt_cause", 32'(halt_cause), 32'(DBG_CAUSE_CMD));
    check("free_halt_done",  32'(steps_done), 32'd0);

    // Reset during STEP_HI
    e0 = edge_cnt;
    send_cmd(DBG_OP_RUN_N, CW'(5));
    check("rstmid_step_hi", 32'(debug_step), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid_step_drop", 32'(debug_step), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rstmid_edges",  32'(edge_cnt - e0), 32'd1);
    check("rstmid_step",   32'(debug_step),    32'd0);
    check("rstmid_halted", 32'(halted),        32'd1);
    check("rstmid_cause",  32'(halt_cause),    32'(DBG_CAUSE_RESET));
    check("rstmid_done",   32'(steps_done),    32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
